// File: rtl/friscv_cache_pkg.sv
// Shared definitions for the friscv N-way cache block storage:
// address-field widths, sweep FSM states and way-index helpers.
package friscv_cache_pkg;

    // Upper bound on ways handled by onehot_to_bin
    localparam int MAX_WAYS = 32;

    typedef enum logic {
        SWEEP = 1'b0,
        IDLE  = 1'b1
    } sweep_state_t;

    function automatic int off_w(input int block_w);
        return $clog2(block_w / 8);
    endfunction

    function automatic int idx_w(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int tag_w(input int addr_w, input int depth, input int block_w);
        return addr_w - idx_w(depth) - off_w(block_w);
    endfunction

    // OR-reduction of set bit positions; exact for one-hot or all-zero inputs
    function automatic int unsigned onehot_to_bin(input logic [MAX_WAYS-1:0] oh);
        int unsigned idx;
        idx = 0;
        for (int i = 0; i < MAX_WAYS; i++) begin
            if (oh[i]) idx = idx | i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/friscv_cache_way_ram.sv
// Storage for a single cache way: per-set valid bit, tag and block payload.
// Reads are combinational; the probe port exposes valid/tag at the fill index.
module friscv_cache_way_ram
    import friscv_cache_pkg::*;
#(
    parameter int DEPTH   = 512,
    parameter int IDX_W   = 9,
    parameter int TAG_W   = 19,
    parameter int BLOCK_W = 128
)(
    input  logic               clk,
    input  logic               clr,
    input  logic [IDX_W-1:0]   clr_idx,
    input  logic               we,
    input  logic [IDX_W-1:0]   widx,
    input  logic [TAG_W-1:0]   wtag,
    input  logic [BLOCK_W-1:0] wblock,
    input  logic [IDX_W-1:0]   ridx,
    output logic               rd_valid,
    output logic [TAG_W-1:0]   rd_tag,
    output logic [BLOCK_W-1:0] rd_block,
    output logic               pr_valid,
    output logic [TAG_W-1:0]   pr_tag
);

    logic               valid_q [DEPTH];
    logic [TAG_W-1:0]   tag_q   [DEPTH];
    logic [BLOCK_W-1:0] block_q [DEPTH];

    // Valid bits are initialised by the sweep, so they carry no reset
    always_ff @(posedge clk) begin
        if (clr) begin
            valid_q[clr_idx] <= 1'b0;
        end else if (we) begin
            valid_q[widx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            tag_q[widx]   <= wtag;
            block_q[widx] <= wblock;
        end
    end

    assign rd_valid = valid_q[ridx];
    assign rd_tag   = tag_q[ridx];
    assign rd_block = block_q[ridx];
    assign pr_valid = valid_q[widx];
    assign pr_tag   = tag_q[widx];

endmodule

// File: rtl/friscv_cache_ways.sv
// N-way set-associative block storage with round-robin victim selection,
// invalid-way-first fill and a self-timed init/flush sweep.
module friscv_cache_ways
    import friscv_cache_pkg::*;
#(
    parameter int ADDR_W        = 32,
    parameter int WLEN          = 32,
    parameter int CACHE_BLOCK_W = 128,
    parameter int CACHE_DEPTH   = 512,
    parameter int CACHE_WAYS    = 2
)(
    input  logic                     aclk,
    input  logic                     srst,
    output logic                     ready,
    input  logic                     flush_req,
    output logic                     flush_ack,
    input  logic                     wen,
    input  logic [ADDR_W-1:0]        waddr,
    input  logic [CACHE_BLOCK_W-1:0] wdata,
    input  logic                     ren,
    input  logic [ADDR_W-1:0]        raddr,
    output logic [WLEN-1:0]          rdata,
    output logic                     hit,
    output logic                     miss
);

    localparam int OFF_W   = off_w(CACHE_BLOCK_W);
    localparam int IDX_W   = idx_w(CACHE_DEPTH);
    localparam int TAG_W   = tag_w(ADDR_W, CACHE_DEPTH, CACHE_BLOCK_W);
    localparam int WSEL_LO = $clog2(WLEN / 8);
    localparam int NWORDS  = CACHE_BLOCK_W / WLEN;
    localparam int WSEL_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam int PTR_W   = (CACHE_WAYS > 1) ? $clog2(CACHE_WAYS) : 1;

    sweep_state_t     state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic             ack_pending_q, ack_pending_d;
    logic             flush_ack_q, flush_ack_d;
    logic             sweeping;

    logic [IDX_W-1:0]  ridx, widx;
    logic [TAG_W-1:0]  rtag, wtag;
    logic [WSEL_W-1:0] word_sel;
    logic              unused_addr;

    logic [CACHE_WAYS-1:0]    rd_valid, pr_valid, rd_match, pr_match, way_we;
    logic [TAG_W-1:0]         rd_tag   [CACHE_WAYS];
    logic [TAG_W-1:0]         pr_tag   [CACHE_WAYS];
    logic [CACHE_BLOCK_W-1:0] rd_block [CACHE_WAYS];

    logic [PTR_W-1:0] vptr [CACHE_DEPTH];
    logic [PTR_W-1:0] fill_way, vptr_next, rd_way;
    logic             fill_en, evict;

    logic [CACHE_BLOCK_W-1:0] rd_sel_block;
    logic [WLEN-1:0]          rd_word;
    logic                     hit_p1, miss_p1;
    logic [WLEN-1:0]          rdata_p1;

    assign sweeping = (state_q == SWEEP);
    assign ridx     = raddr[OFF_W +: IDX_W];
    assign rtag     = raddr[OFF_W+IDX_W +: TAG_W];
    assign widx     = waddr[OFF_W +: IDX_W];
    assign wtag     = waddr[OFF_W+IDX_W +: TAG_W];
    assign unused_addr = ^{waddr[OFF_W-1:0], raddr[OFF_W-1:0]};

    generate
        if (NWORDS > 1) begin : g_wsel
            assign word_sel = raddr[WSEL_LO +: WSEL_W];
        end else begin : g_wsel_none
            assign word_sel = '0;
        end
    endgenerate

    generate
        for (genvar w = 0; w < CACHE_WAYS; w++) begin : g_way
            friscv_cache_way_ram #(
                .DEPTH   (CACHE_DEPTH),
                .IDX_W   (IDX_W),
                .TAG_W   (TAG_W),
                .BLOCK_W (CACHE_BLOCK_W)
            ) u_ram (
                .clk      (aclk),
                .clr      (sweeping),
                .clr_idx  (cnt_q),
                .we       (way_we[w]),
                .widx     (widx),
                .wtag     (wtag),
                .wblock   (wdata),
                .ridx     (ridx),
                .rd_valid (rd_valid[w]),
                .rd_tag   (rd_tag[w]),
                .rd_block (rd_block[w]),
                .pr_valid (pr_valid[w]),
                .pr_tag   (pr_tag[w])
            );
            assign rd_match[w] = rd_valid[w] && (rd_tag[w] == rtag);
            assign pr_match[w] = pr_valid[w] && (pr_tag[w] == wtag);
            assign way_we[w]   = fill_en && (fill_way == PTR_W'(w));
        end
    endgenerate

    // Fill way: existing tag, then lowest invalid way, then round-robin victim
    always_comb begin
        fill_en   = wen && !sweeping && !srst;
        fill_way  = vptr[widx];
        evict     = 1'b0;
        vptr_next = (vptr[widx] == PTR_W'(CACHE_WAYS-1)) ? '0 : vptr[widx] + 1'b1;
        if (|pr_match) begin
            fill_way = PTR_W'(onehot_to_bin(MAX_WAYS'(pr_match)));
        end else if (!(&pr_valid)) begin
            for (int i = CACHE_WAYS-1; i >= 0; i--) begin
                if (!pr_valid[i]) fill_way = PTR_W'(i);
            end
        end else begin
            evict = 1'b1;
        end
    end

    always_ff @(posedge aclk) begin
        if (sweeping) begin
            vptr[cnt_q] <= '0;
        end else if (fill_en && evict) begin
            vptr[widx] <= vptr_next;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        ack_pending_d = ack_pending_q;
        flush_ack_d   = 1'b0;
        case (state_q)
            SWEEP: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == IDX_W'(CACHE_DEPTH-1)) begin
                    state_d       = IDLE;
                    cnt_d         = '0;
                    flush_ack_d   = ack_pending_q;
                    ack_pending_d = 1'b0;
                end
            end
            IDLE: begin
                if (flush_req) begin
                    state_d       = SWEEP;
                    cnt_d         = '0;
                    ack_pending_d = 1'b1;
                end
            end
            default: state_d = SWEEP;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (srst) begin
            state_q       <= SWEEP;
            cnt_q         <= '0;
            ack_pending_q <= 1'b0;
            flush_ack_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            ack_pending_q <= ack_pending_d;
            flush_ack_q   <= flush_ack_d;
        end
    end

    assign rd_way       = PTR_W'(onehot_to_bin(MAX_WAYS'(rd_match)));
    assign rd_sel_block = rd_block[rd_way];
    assign rd_word      = rd_sel_block[word_sel*WLEN +: WLEN];

    // Stage p1: registered read result; rdata holds on miss
    always_ff @(posedge aclk) begin
        if (srst) begin
            hit_p1   <= 1'b0;
            miss_p1  <= 1'b0;
            rdata_p1 <= '0;
        end else begin
            hit_p1  <= ren && !sweeping && (|rd_match);
            miss_p1 <= ren && (sweeping || !(|rd_match));
            if (ren && !sweeping && (|rd_match)) rdata_p1 <= rd_word;
        end
    end

    always_ff @(posedge aclk) begin
        if (!srst && ren && !sweeping) begin
            assert ($onehot0(rd_match))
            else $error("friscv_cache_ways: several ways match one tag");
        end
    end

    assign ready     = !sweeping;
    assign flush_ack = flush_ack_q;
    assign hit       = hit_p1;
    assign miss      = miss_p1;
    assign rdata     = rdata_p1;

endmodule

// File: tb/tb_friscv_cache_ways.sv
// Directed bench for friscv_cache_ways with 4 sets, 2 ways, 128-bit blocks.
module tb_friscv_cache_ways;

    logic         aclk = 1'b0;
    logic         srst = 1'b1;
    logic         ready;
    logic         flush_req = 1'b0;
    logic         flush_ack;
    logic         wen = 1'b0;
    logic [31:0]  waddr = '0;
    logic [127:0] wdata = '0;
    logic         ren = 1'b0;
    logic [31:0]  raddr = '0;
    logic [31:0]  rdata;
    logic         hit;
    logic         miss;

    int vectors     = 0;
    int miscompares = 0;

    friscv_cache_ways #(
        .ADDR_W        (32),
        .WLEN          (32),
        .CACHE_BLOCK_W (128),
        .CACHE_DEPTH   (4),
        .CACHE_WAYS    (2)
    ) dut (
        .aclk      (aclk),
        .srst      (srst),
        .ready     (ready),
        .flush_req (flush_req),
        .flush_ack (flush_ack),
        .wen       (wen),
        .waddr     (waddr),
        .wdata     (wdata),
        .ren       (ren),
        .raddr     (raddr),
        .rdata     (rdata),
        .hit       (hit),
        .miss      (miss)
    );

    always #5 aclk = ~aclk;

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    function automatic logic [127:0] mk(input logic [31:0] base);
        return {base + 32'd3, base + 32'd2, base + 32'd1, base};
    endfunction

    task automatic fill(input logic [31:0] a, input logic [127:0] d);
        wen = 1'b1; waddr = a; wdata = d;
        step();
        wen = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a);
        ren = 1'b1; raddr = a;
        step();
        ren = 1'b0;
    endtask

    task automatic reset_wait();
        int n;
        srst = 1'b1;
        step();
        srst = 1'b0;
        n = 0;
        while (ready !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        vectors++;
        if (ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_wait: ready=%b after %0d cycles, expected 1", ready, n);
        end
    endtask

    task automatic test_reset();
        srst = 1'b1;
        step();
        vectors++;
        if ({ready, flush_ack, hit, miss} !== 4'b0000 || rdata !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_values: ready/ack/hit/miss=%b rdata=%h, expected 0000 and 0",
                     {ready, flush_ack, hit, miss}, rdata);
        end
        srst = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            step();
            vectors++;
            if (ready !== 1'(i == 4) || flush_ack !== 1'b0) begin
                miscompares++;
                $display("FAIL init_sweep cycle %0d: ready=%b flush_ack=%b, expected ready=%b flush_ack=0",
                         i, ready, flush_ack, 1'(i == 4));
            end
        end
        rd(32'h0);
        vectors++;
        if (hit !== 1'b0 || miss !== 1'b1) begin
            miscompares++;
            $display("FAIL init_read: hit=%b miss=%b, expected hit=0 miss=1", hit, miss);
        end
        step();
        vectors++;
        if (hit !== 1'b0 || miss !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_flags: hit=%b miss=%b, expected 0 0", hit, miss);
        end
    endtask

    task automatic test_basic_hit();
        reset_wait();
        fill(32'h00, {32'hDEADBEEF, 32'h0000_2222, 32'h0000_1111, 32'h0000_1000});
        rd(32'h0C);
        vectors++;
        if (hit !== 1'b1 || miss !== 1'b0 || rdata !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL basic_hit_w3: hit=%b miss=%b rdata=%h, expected 1 0 deadbeef", hit, miss, rdata);
        end
        rd(32'h04);
        vectors++;
        if (hit !== 1'b1 || rdata !== 32'h0000_1111) begin
            miscompares++;
            $display("FAIL basic_hit_w1: hit=%b rdata=%h, expected 1 00001111", hit, rdata);
        end
    endtask

    task automatic test_replacement();
        reset_wait();
        fill(32'h00, mk(32'hA000_0000));
        fill(32'h40, mk(32'hB000_0000));
        fill(32'h80, mk(32'hC000_0000));
        rd(32'h40);
        vectors++;
        if (hit !== 1'b1 || rdata !== 32'hB000_0000) begin
            miscompares++;
            $display("FAIL repl_0x40: hit=%b rdata=%h, expected 1 b0000000", hit, rdata);
        end
        rd(32'h00);
        vectors++;
        if (hit !== 1'b0 || miss !== 1'b1 || rdata !== 32'hB000_0000) begin
            miscompares++;
            $display("FAIL repl_0x00_evicted: hit=%b miss=%b rdata=%h, expected 0 1 b0000000 (held)",
                     hit, miss, rdata);
        end
        rd(32'h84);
        vectors++;
        if (hit !== 1'b1 || rdata !== 32'hC000_0001) begin
            miscompares++;
            $display("FAIL repl_0x80: hit=%b rdata=%h, expected 1 c0000001", hit, rdata);
        end
        fill(32'hC0, mk(32'hD000_0000));
        rd(32'h40);
        vectors++;
        if (hit !== 1'b0 || miss !== 1'b1) begin
            miscompares++;
            $display("FAIL repl_0x40_evicted: hit=%b miss=%b, expected 0 1", hit, miss);
        end
        rd(32'h80);
        vectors++;
        if (hit !== 1'b1 || rdata !== 32'hC000_0000) begin
            miscompares++;
            $display("FAIL repl_0x80_kept: hit=%b rdata=%h, expected 1 c0000000", hit, rdata);
        end
        rd(32'hCC);
        vectors++;
        if (hit !== 1'b1 || rdata !== 32'hD000_0003) begin
            miscompares++;
            $display("FAIL repl_0xC0: hit=%b rdata=%h, expected 1 d0000003", hit, rdata);
        end
    endtask

    task automatic test_refill();
        reset_wait();
        fill(32'h00, mk(32'h1100_0000));
        fill(32'h40, mk(32'h2200_0000));
        fill(32'h00, mk(32'h3300_0000));
        rd(32'h08);
        vectors++;
        if (hit !== 1'b1 || rdata !== 32'h3300_0002) begin
            miscompares++;
            $display("FAIL refill_data: hit=%b rdata=%h, expected 1 33000002", hit, rdata);
        end
        fill(32'h80, mk(32'h4400_0000));
        rd(32'h00);
        vectors++;
        if (hit !== 1'b0 || miss !== 1'b1) begin
            miscompares++;
            $display("FAIL refill_way0_evicted: hit=%b miss=%b, expected 0 1", hit, miss);
        end
        rd(32'h44);
        vectors++;
        if (hit !== 1'b1 || rdata !== 32'h2200_0001) begin
            miscompares++;
            $display("FAIL refill_way1_kept: hit=%b rdata=%h, expected 1 22000001", hit, rdata);
        end
        rd(32'h80);
        vectors++;
        if (hit !== 1'b1 || rdata !== 32'h4400_0000) begin
            miscompares++;
            $display("FAIL refill_new_tag: hit=%b rdata=%h, expected 1 44000000", hit, rdata);
        end
    endtask

    task automatic test_same_cycle();
        wen = 1'b1; waddr = 32'h10; wdata = mk(32'h5500_0000);
        ren = 1'b1; raddr = 32'h10;
        step();
        wen = 1'b0; ren = 1'b0;
        vectors++;
        if (hit !== 1'b0 || miss !== 1'b1) begin
            miscompares++;
            $display("FAIL same_cycle_rw: hit=%b miss=%b, expected 0 1", hit, miss);
        end
        rd(32'h14);
        vectors++;
        if (hit !== 1'b1 || rdata !== 32'h5500_0001) begin
            miscompares++;
            $display("FAIL read_after_fill: hit=%b rdata=%h, expected 1 55000001", hit, rdata);
        end
    endtask

    task automatic test_flush();
        logic [31:0] addrs [5];
        addrs[0] = 32'h00; addrs[1] = 32'h10; addrs[2] = 32'h20;
        addrs[3] = 32'h30; addrs[4] = 32'h40;
        reset_wait();
        for (int s = 0; s < 4; s++) fill(addrs[s], mk(32'h6000_0000 + 32'(s << 8)));
        rd(32'h30);
        vectors++;
        if (hit !== 1'b1 || rdata !== 32'h6000_0300) begin
            miscompares++;
            $display("FAIL flush_prefill: hit=%b rdata=%h, expected 1 60000300", hit, rdata);
        end
        flush_req = 1'b1;
        step();
        flush_req = 1'b0;
        vectors++;
        if (ready !== 1'b0 || flush_ack !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_start: ready=%b flush_ack=%b, expected 0 0", ready, flush_ack);
        end
        for (int i = 1; i <= 4; i++) begin
            if (i == 2) begin
                wen = 1'b1; waddr = 32'h40; wdata = mk(32'h7700_0000);
                ren = 1'b1; raddr = 32'h30;
            end
            if (i == 3) flush_req = 1'b1;
            step();
            wen = 1'b0; ren = 1'b0; flush_req = 1'b0;
            vectors++;
            if (ready !== 1'(i == 4) || flush_ack !== 1'(i == 4)) begin
                miscompares++;
                $display("FAIL flush_sweep cycle %0d: ready=%b flush_ack=%b, expected %b %b",
                         i, ready, flush_ack, 1'(i == 4), 1'(i == 4));
            end
            if (i == 2) begin
                vectors++;
                if (hit !== 1'b0 || miss !== 1'b1) begin
                    miscompares++;
                    $display("FAIL sweep_read: hit=%b miss=%b, expected 0 1", hit, miss);
                end
            end
        end
        step();
        vectors++;
        if (flush_ack !== 1'b0 || ready !== 1'b1) begin
            miscompares++;
            $display("FAIL flush_ack_pulse: flush_ack=%b ready=%b, expected 0 1", flush_ack, ready);
        end
        for (int s = 0; s < 5; s++) begin
            rd(addrs[s]);
            vectors++;
            if (hit !== 1'b0 || miss !== 1'b1) begin
                miscompares++;
                $display("FAIL post_flush_read %h: hit=%b miss=%b, expected 0 1", addrs[s], hit, miss);
            end
        end
        // srst two cycles into a flush sweep
        fill(32'h00, mk(32'h8800_0000));
        flush_req = 1'b1;
        step();
        flush_req = 1'b0;
        step();
        step();
        srst = 1'b1;
        step();
        srst = 1'b0;
        vectors++;
        if (ready !== 1'b0 || flush_ack !== 1'b0) begin
            miscompares++;
            $display("FAIL srst_mid_sweep: ready=%b flush_ack=%b, expected 0 0", ready, flush_ack);
        end
        for (int i = 1; i <= 6; i++) begin
            step();
            vectors++;
            if (ready !== 1'(i >= 4) || flush_ack !== 1'b0) begin
                miscompares++;
                $display("FAIL restart_sweep cycle %0d: ready=%b flush_ack=%b, expected %b 0",
                         i, ready, flush_ack, 1'(i >= 4));
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_hit();
        test_replacement();
        test_refill();
        test_same_cycle();
        test_flush();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
